instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 o_imem_req_valid  output  1  fetch request valid.
REQ-007 o_imem_req_addr  output  XLEN  word-aligned fetch address.
REQ-008 i_imem_req_ready  input  1  memory accepts request this cycle.
REQ-009 i_imem_resp_valid  input  1  in-order response data valid.
REQ-010 i_imem_resp_data  input  XLEN  fetched instruction word.
REQ-011 i_redirect  input  1  branch/jump taken; refetch from i_redirect_pc.
REQ-012 i_redirect_pc  input  XLEN  redirect target.
REQ-013 o_instr_valid  output  1  o_instruction/o_pc valid toward decode.
REQ-014 o_instruction  output  XLEN  instruction word for decode.
REQ-015 o_pc  output  XLEN  address of o_instruction.
REQ-016 i_instr_ready  input  1  decode consumes head this cycle.

Function
REQ-017 Request handshake SHALL complete when o_imem_req_valid & i_imem_req_ready; fetch pc then advances by 4 (wraps modulo 2^XLEN).
REQ-018 o_imem_req_valid SHALL assert only when state is S_FETCH and outstanding + FIFO occupancy < FIFO_DEPTH (credit rule; FIFO never overflows).
REQ-019 Once asserted, o_imem_req_valid/o_imem_req_addr SHALL stay stable until accepted, except withdrawal on i_redirect.
REQ-020 Outstanding counter ($clog2(FIFO_DEPTH)+1 bits) SHALL increment on request accept, decrement on kept or dropped response; both same cycle = unchanged.
REQ-021 Kept responses SHALL push {pc, data} into FIFO; pc is the address of the matching accepted request, tracked in request order.
REQ-022 Output SHALL be FIFO head; pop on o_instr_valid & i_instr_ready; push and pop same cycle allowed at any occupancy.
REQ-023 When FIFO empty, o_instr_valid SHALL be 0, o_instruction SHALL be RV_NOP (32'h0000_0013), o_pc SHALL be 0.
REQ-024 Minimum latency: response in cycle N SHALL appear on o_instr_valid in cycle N+1.
REQ-025 FSM states: S_FETCH (issue), S_DRAIN (discard stale responses, no issue).
REQ-026 i_redirect SHALL have priority over all events: in that cycle no request issued, FIFO flushed, pop ignored, any arriving response discarded, fetch pc <= {i_redirect_pc[XLEN-1:2], 2'b00}.
REQ-027 On i_redirect, drop counter SHALL load outstanding after this cycle's events; nonzero -> S_DRAIN, zero -> S_FETCH.
REQ-028 In S_DRAIN each response SHALL be discarded and decrement drop counter; at zero return to S_FETCH next cycle.
REQ-029 Redirect while in S_DRAIN SHALL reload drop counter per REQ-027 and update pc; no stale response may reach the FIFO.
REQ-030 A response with zero outstanding SHALL be ignored.

Reset
REQ-031 While i_rst is high: pc <= RESET_PC, state <= S_FETCH, FIFO empty, outstanding and drop counters 0, o_imem_req_valid 0, o_instr_valid 0, o_instruction RV_NOP, o_pc 0.
REQ-032 Responses during reset SHALL be ignored; instruction memory is reset with this block, so none arrive afterward for pre-reset requests.
REQ-033 First request SHALL be issued the first cycle i_rst is low, address RESET_PC.

Structure
REQ-034 rapid_pkg SHALL hold XLEN, RV_NOP constant, fetch_state_e enum {S_FETCH, S_DRAIN}.
REQ-035 Buffer SHALL be sub-module fetch_fifo (synchronous, parameterised depth, storing {pc, instruction}, full/empty/count outputs, flush input).
REQ-036 Outputs SHALL drive decoder_logic's instruction input and the decode pipeline register without extra combinational logic beyond the empty-NOP mux.

Verification
REQ-037 Reset release, ready=1, 1-cycle memory, decode ready=1 -> requests 0x0,0x4,0x8...; o_pc 0x0 with valid in cycle 3 after release, one instruction per cycle thereafter.
REQ-038 Decode ready=0 for 10 cycles -> at most FIFO_DEPTH requests outstanding+buffered; no response lost; order preserved after release.
REQ-039 Two requests outstanding, i_redirect to 0x100 -> both late responses discarded, next request address 0x100, first valid o_pc 0x100.
REQ-040 i_redirect_pc 0x203 -> request address 0x200.
REQ-041 Redirect in same cycle as response and pop with FIFO full -> FIFO empty next cycle, drop counter equals remaining outstanding.
REQ-042 i_rst asserted mid-stream with outstanding requests -> next cycle all outputs at reset values; first post-reset request at RESET_PC.

Source files
------------

// File: rtl/rapid_pkg.sv
// Shared fetch-stage constants and types.
package rapid_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0 -- presented to decode whenever the buffer is empty
   localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [0:0] {
      S_FETCH,
      S_DRAIN
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {pc, instruction} pairs.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   // Status flags and handshake qualification; a push into a full buffer is legal
   // when the head leaves in the same cycle.
   always_comb begin
      empty_o = (count_q == '0);
      full_o  = (count_q == CW'(DEPTH));
      pop_ok  = pop_i && !empty_o;
      push_ok = push_i && (!full_o || pop_ok);
      count_o = count_q;
      head_o  = mem_q[rd_ptr_q];
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   // Pointer and occupancy state; flush discards everything in one cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Storage array, no reset needed since occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: credit-limited in-order requests to instruction memory,
// response buffering toward decode, and redirect handling with stale-response drain.
module instruction_fetch
   import rapid_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req_valid,
   output logic [XLEN-1:0] o_imem_req_addr,
   input  logic            i_imem_req_ready,
   input  logic            i_imem_resp_valid,
   input  logic [XLEN-1:0] i_imem_resp_data,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_instr_valid,
   output logic [XLEN-1:0] o_instruction,
   output logic [XLEN-1:0] o_pc,
   input  logic            i_instr_ready
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   // pc of the oldest live outstanding request; responses return in request order
   logic [XLEN-1:0] resp_pc_q;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q;

   logic [2*XLEN-1:0] fifo_head;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       credit_used;
   logic              req_fire, resp_take, resp_keep, pop;

   // Issue, response-acceptance and pop decisions for this cycle.
   always_comb begin
      credit_used      = {1'b0, outstanding_q} + {1'b0, fifo_count};
      o_imem_req_valid = !i_rst && !i_redirect && (state_q == S_FETCH) && !fifo_full &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
      o_imem_req_addr  = pc_q;
      req_fire         = o_imem_req_valid && i_imem_req_ready;
      // a response with nothing outstanding is not ours to count
      resp_take        = !i_rst && i_imem_resp_valid && (outstanding_q != '0);
      resp_keep        = resp_take && (state_q == S_FETCH) && !i_redirect;
      pop              = !fifo_empty && i_instr_ready && !i_redirect;
      outstanding_d    = outstanding_q;
      if (req_fire && !resp_take) begin
         outstanding_d = outstanding_q + CW'(1);
      end else if (resp_take && !req_fire) begin
         outstanding_d = outstanding_q - CW'(1);
      end
   end

   // Head of buffer straight to decode, NOP and zero pc when empty.
   always_comb begin
      o_instr_valid = !fifo_empty;
      o_instruction = fifo_empty ? RV_NOP : fifo_head[XLEN-1:0];
      o_pc          = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];
   end

   // Fetch FSM, pc and counters; redirect overrides every other event.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= S_FETCH;
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         if (i_redirect) begin
            pc_q      <= {i_redirect_pc[XLEN-1:2], 2'b00};
            resp_pc_q <= {i_redirect_pc[XLEN-1:2], 2'b00};
            drop_q    <= outstanding_d;
            state_q   <= (outstanding_d != '0) ? S_DRAIN : S_FETCH;
         end else begin
            if (req_fire)  pc_q      <= pc_q + XLEN'(4);
            if (resp_keep) resp_pc_q <= resp_pc_q + XLEN'(4);
            case (state_q)
               S_FETCH: ;
               S_DRAIN: begin
                  if (drop_q == '0) begin
                     state_q <= S_FETCH;
                  end else if (resp_take) begin
                     drop_q <= drop_q - CW'(1);
                     if (drop_q == CW'(1)) state_q <= S_FETCH;
                  end
               end
               default: state_q <= S_FETCH;
            endcase
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk_i       (i_clk),
      .rst_i       (i_rst),
      .flush_i     (i_redirect),
      .push_i      (resp_keep),
      .push_data_i ({resp_pc_q, i_imem_resp_data}),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a queue-based reference model.
module tb_instruction_fetch;
   import rapid_pkg::*;

   localparam int unsigned    DEPTH = 4;
   localparam logic [31:0]    RPC   = 32'h0000_0000;

   logic        i_clk, i_rst;
   logic        o_imem_req_valid;
   logic [31:0] o_imem_req_addr;
   logic        i_imem_req_ready, i_imem_resp_valid;
   logic [31:0] i_imem_resp_data;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_instr_valid;
   logic [31:0] o_instruction, o_pc;
   logic        i_instr_ready;

   instruction_fetch #(
      .RESET_PC   (RPC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .o_imem_req_valid  (o_imem_req_valid),
      .o_imem_req_addr   (o_imem_req_addr),
      .i_imem_req_ready  (i_imem_req_ready),
      .i_imem_resp_valid (i_imem_resp_valid),
      .i_imem_resp_data  (i_imem_resp_data),
      .i_redirect        (i_redirect),
      .i_redirect_pc     (i_redirect_pc),
      .o_instr_valid     (o_instr_valid),
      .o_instruction     (o_instruction),
      .o_pc              (o_pc),
      .i_instr_ready     (i_instr_ready)
   );

   initial i_clk = 0;
   always #5 i_clk = ~i_clk;

   // reference model: outstanding requests (pc, stale flag, memory due cycle) and buffer
   logic [31:0] oq_pc[$];
   bit          oq_stale[$];
   int          oq_due[$];
   logic [63:0] fq[$];
   logic [31:0] m_pc;
   int          cyc;

   int n_total, n_pass;
   bit          s_rv, s_iv;
   logic [31:0] s_addr, s_instr, s_pc;

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   function automatic bit has_stale();
      foreach (oq_stale[k]) if (oq_stale[k]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
      else
         n_pass++;
   endtask

   // One clock cycle: drive inputs, compare at negedge, advance model at posedge.
   task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                       input bit dec_rdy, input bit mem_rdy, input bit spur, input int lat_max);
      bit rv, e_rv, e_iv, pop, acc, taken, st;
      logic [31:0] rd, e_instr, e_pc, p;
      int d;
      rv = 0;
      rd = '0;
      if (!rst && oq_pc.size() > 0) begin
         if (oq_due[0] <= cyc) begin
            rv = 1;
            rd = memdata(oq_pc[0]);
         end
      end else if (oq_pc.size() == 0 && spur) begin
         rv = 1;
         rd = $urandom;
      end
      i_rst = rst; i_redirect = redir; i_redirect_pc = rpc;
      i_instr_ready = dec_rdy; i_imem_req_ready = mem_rdy;
      i_imem_resp_valid = rv; i_imem_resp_data = rd;

      @(negedge i_clk);
      e_rv    = !rst && !redir && !has_stale() && (oq_pc.size() + fq.size() < DEPTH);
      e_iv    = fq.size() > 0;
      e_instr = e_iv ? fq[0][31:0] : 32'h0000_0013;
      e_pc    = e_iv ? fq[0][63:32] : 32'h0;
      s_rv = o_imem_req_valid; s_addr = o_imem_req_addr;
      s_iv = o_instr_valid; s_instr = o_instruction; s_pc = o_pc;
      chk("req_valid", {31'b0, s_rv}, {31'b0, e_rv});
      if (e_rv) chk("req_addr", s_addr, m_pc);
      chk("instr_valid", {31'b0, s_iv}, {31'b0, e_iv});
      chk("instruction", s_instr, e_instr);
      chk("pc", s_pc, e_pc);

      @(posedge i_clk);
      acc   = e_rv && mem_rdy;
      taken = rv && !rst && oq_pc.size() > 0;
      if (rst) begin
         oq_pc.delete(); oq_stale.delete(); oq_due.delete(); fq.delete();
         m_pc = RPC;
      end else begin
         pop = e_iv && dec_rdy && !redir;
         if (pop) void'(fq.pop_front());
         if (taken) begin
            p  = oq_pc.pop_front();
            st = oq_stale.pop_front();
            void'(oq_due.pop_front());
            if (!st && !redir) fq.push_back({p, rd});
         end
         if (redir) begin
            fq.delete();
            foreach (oq_stale[k]) oq_stale[k] = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
         end else if (acc) begin
            d = cyc + int'($urandom_range(lat_max, 1));
            if (oq_due.size() > 0 && oq_due[oq_due.size()-1] > d) d = oq_due[oq_due.size()-1];
            oq_pc.push_back(m_pc); oq_stale.push_back(1'b0); oq_due.push_back(d);
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
      #1;
   endtask

   // Redirect now, then report the first issued address and first delivered pc.
   task automatic redirect_and_track(input logic [31:0] target, input logic [31:0] exp_addr,
                                     input string tag);
      bit got_rv, got_iv;
      logic [31:0] first_addr, first_pc;
      got_rv = 0; got_iv = 0; first_addr = '0; first_pc = '0;
      step(0, 1, target, 1, 1, 0, 3);
      for (int i = 0; i < 40 && !got_iv; i++) begin
         step(0, 0, 0, 1, 1, 0, 1);
         if (s_rv && !got_rv) begin got_rv = 1; first_addr = s_addr; end
         if (s_iv && !got_iv) begin got_iv = 1; first_pc = s_pc; end
      end
      chk({tag, "_seen"}, {30'b0, got_rv, got_iv}, 32'h3);
      chk({tag, "_first_addr"}, first_addr, exp_addr);
      chk({tag, "_first_pc"}, first_pc, exp_addr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout cycle=%0d actual=running required=finished", cyc);
      $fatal(1);
   end

   bit          cap_rv[6], cap_iv[6];
   logic [31:0] cap_addr[6], cap_pc[6], cap_instr[6];
   int          thr;

   initial begin
      n_total = 0; n_pass = 0; cyc = 0; m_pc = RPC;
      i_rst = 1; i_redirect = 0; i_redirect_pc = '0; i_instr_ready = 0;
      i_imem_req_ready = 0; i_imem_resp_valid = 0; i_imem_resp_data = '0;
      repeat (3) @(posedge i_clk);
      #1;

      // reset values
      step(1, 0, 0, 1, 1, 1, 1);
      chk("rst_req_valid", {31'b0, s_rv}, 32'h0);
      chk("rst_instr_valid", {31'b0, s_iv}, 32'h0);
      chk("rst_instruction", s_instr, 32'h0000_0013);
      chk("rst_pc", s_pc, 32'h0);

      // first cycles after release with single-cycle memory
      for (int i = 1; i <= 5; i++) begin
         step(0, 0, 0, 1, 1, 0, 1);
         cap_rv[i] = s_rv; cap_iv[i] = s_iv; cap_addr[i] = s_addr;
         cap_pc[i] = s_pc; cap_instr[i] = s_instr;
      end
      chk("rel_c1_req", {cap_rv[1], cap_addr[1][30:0]}, 32'h8000_0000);
      chk("rel_c2_addr", cap_addr[2], 32'h4);
      chk("rel_c2_iv", {31'b0, cap_iv[2]}, 32'h0);
      chk("rel_c3_pc", {cap_iv[3], cap_pc[3][30:0]}, 32'h8000_0000);
      chk("rel_c3_instr", cap_instr[3], 32'hC0DE_0000);
      chk("rel_c4_pc", {cap_iv[4], cap_pc[4][30:0]}, 32'h8000_0004);
      chk("rel_c5_pc", {cap_iv[5], cap_pc[5][30:0]}, 32'h8000_0008);

      // redirect with two requests in flight
      begin
         int n;
         n = 0;
         while (oq_pc.size() != 2 && n < 20) begin
            step(0, 0, 0, 1, 1, 0, 3);
            n++;
         end
         chk("two_outstanding", oq_pc.size(), 2);
      end
      redirect_and_track(32'h0000_0100, 32'h0000_0100, "redir100");
      redirect_and_track(32'h0000_0203, 32'h0000_0200, "redir203");

      // reset mid-stream
      repeat (4) step(0, 0, 0, 0, 1, 0, 3);
      step(1, 0, 0, 1, 1, 0, 3);
      step(0, 0, 0, 1, 1, 0, 1);
      chk("postrst_req", {s_rv, s_addr[30:0]}, {1'b1, RPC[30:0]});
      chk("postrst_iv", {31'b0, s_iv}, 32'h0);
      chk("postrst_instr", s_instr, 32'h0000_0013);
      chk("postrst_pc", s_pc, 32'h0);

      // randomized traffic: stalls, redirects (some near wrap), spurious responses, resets
      thr = 100;
      for (int n = 0; n < 3000; n++) begin
         bit rst, redir;
         logic [31:0] rpc;
         if (n % 100 == 0) begin
            case ($urandom_range(3, 0))
               0: thr = 0;
               1: thr = 30;
               2: thr = 70;
               default: thr = 100;
            endcase
         end
         rst   = ($urandom_range(399, 0) == 0);
         redir = ($urandom_range(15, 0) == 0);
         rpc   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         step(rst, redir, rpc, ($urandom_range(99, 0) < thr), ($urandom_range(99, 0) < 75),
              ($urandom_range(9, 0) == 0), 3);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
